// File: rtl/mem_acc_stage_if.sv
// ---------------------------------------------------------------------------
// mem_acc_stage_if
// Data-memory request/acknowledge bus between the memory-access stage and
// the data memory.
//   dmemReq   : request, held until acknowledge or abort (master -> slave)
//   dmemWe    : write enable, valid while dmemReq=1      (master -> slave)
//   dmemAddr  : word-aligned byte address                (master -> slave)
//   dmemWdata : store data                               (master -> slave)
//   dmemRdata : load data, valid with dmemAck            (slave -> master)
//   dmemAck   : single-cycle acknowledge                 (slave -> master)
// ---------------------------------------------------------------------------
interface mem_acc_stage_if #(
   parameter int DATA_W = 32
);
   logic              dmemReq;
   logic              dmemWe;
   logic [DATA_W-1:0] dmemAddr;
   logic [DATA_W-1:0] dmemWdata;
   logic [DATA_W-1:0] dmemRdata;
   logic              dmemAck;

   modport master (
      output dmemReq,
      output dmemWe,
      output dmemAddr,
      output dmemWdata,
      input  dmemRdata,
      input  dmemAck
   );

   modport slave (
      input  dmemReq,
      input  dmemWe,
      input  dmemAddr,
      input  dmemWdata,
      output dmemRdata,
      output dmemAck
   );
endinterface

// File: rtl/mem_acc_stage.sv
// ---------------------------------------------------------------------------
// mem_acc_stage
// Memory-access stage of the multicycle CPU. Latches the execute-stage
// results on memStart, runs at most one data-memory transaction on the
// dmem bus, captures load data into lmdOut and produces the next PC with a
// one-cycle pcWe strobe. Misaligned or read+write requests and bus
// timeouts end in a one-cycle memErr pulse instead.
// Ports:
//   clk, rstN                  : clock (rising edge), async active-low reset
//   memStart                   : one-cycle start pulse (ignored while busy)
//   memRead/memWrite           : load / store request
//   branchSig/condOut          : conditional branch and its condition
//   aluOOut/regBOut/npcOut     : address or target, store data, PC+4
//   dmem                       : data-memory bus (master side)
//   lmdOut                     : load memory data register
//   pcNext/pcWe                : next PC and its write strobe
//   memDone/memErr             : completion / fault pulses
//   busy                       : high whenever the stage is not idle
// ---------------------------------------------------------------------------
module mem_acc_stage #(
   parameter int TIMEOUT = 15,
   parameter int DATA_W  = 32
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              memStart,
   input  logic              memRead,
   input  logic              memWrite,
   input  logic              branchSig,
   input  logic              condOut,
   input  logic [DATA_W-1:0] aluOOut,
   input  logic [DATA_W-1:0] regBOut,
   input  logic [DATA_W-1:0] npcOut,
   mem_acc_stage_if.master   dmem,
   output logic [DATA_W-1:0] lmdOut,
   output logic [DATA_W-1:0] pcNext,
   output logic              pcWe,
   output logic              memDone,
   output logic              memErr,
   output logic              busy
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] REQ  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   // Counter compare value: the abort happens on the edge that would bring
   // the wait count up to TIMEOUT, so dmemReq is high exactly TIMEOUT cycles.
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [1:0]        r_state;
   logic [7:0]        r_cnt;
   logic [DATA_W-1:0] r_alu;
   logic [DATA_W-1:0] r_npc;
   logic              r_read;
   logic              r_write;
   logic              r_branch;
   logic              r_cond;

   logic [1:0]        w_next;
   logic              w_start;
   logic              w_fault;
   logic [DATA_W-1:0] w_alu;
   logic [DATA_W-1:0] w_npc;
   logic              w_write;
   logic              w_taken;

   assign w_start = (r_state == IDLE) && memStart;
   assign w_fault = (memRead && memWrite) ||
                    ((memRead || memWrite) && (aluOOut[1:0] != 2'b00));

   // On the start edge the registered outputs must already reflect the new
   // operation, so the effective operands bypass the capture registers.
   assign w_alu   = w_start ? aluOOut  : r_alu;
   assign w_npc   = w_start ? npcOut   : r_npc;
   assign w_write = w_start ? memWrite : r_write;
   assign w_taken = w_start ? (branchSig && condOut) : (r_branch && r_cond);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (memStart) begin
               if (w_fault)
                  w_next = ERR;
               else if (memRead || memWrite)
                  w_next = REQ;
               else
                  w_next = DONE;
            end
         end
         REQ: begin
            // An ack arriving on the final allowed cycle still completes.
            if (dmem.dmemAck)
               w_next = DONE;
            else if (r_cnt == TMO_LAST)
               w_next = ERR;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         r_state        <= IDLE;
         r_cnt          <= 8'd0;
         r_alu          <= '0;
         r_npc          <= '0;
         r_read         <= 1'b0;
         r_write        <= 1'b0;
         r_branch       <= 1'b0;
         r_cond         <= 1'b0;
         dmem.dmemReq   <= 1'b0;
         dmem.dmemWe    <= 1'b0;
         dmem.dmemAddr  <= '0;
         dmem.dmemWdata <= '0;
         lmdOut         <= '0;
         pcNext         <= '0;
         pcWe           <= 1'b0;
         memDone        <= 1'b0;
         memErr         <= 1'b0;
         busy           <= 1'b0;
      end else begin
         r_state      <= w_next;
         busy         <= (w_next != IDLE);
         memDone      <= (w_next == DONE);
         pcWe         <= (w_next == DONE);
         memErr       <= (w_next == ERR);
         dmem.dmemReq <= (w_next == REQ);
         dmem.dmemWe  <= (w_next == REQ) && w_write;

         if (w_start) begin
            r_alu    <= aluOOut;
            r_npc    <= npcOut;
            r_read   <= memRead;
            r_write  <= memWrite;
            r_branch <= branchSig;
            r_cond   <= condOut;
            r_cnt    <= 8'd0;
            if (w_next == REQ) begin
               dmem.dmemAddr  <= aluOOut;
               dmem.dmemWdata <= memWrite ? regBOut : '0;
            end
         end

         if ((r_state == REQ) && !dmem.dmemAck)
            r_cnt <= r_cnt + 8'd1;

         if ((r_state == REQ) && dmem.dmemAck && r_read)
            lmdOut <= dmem.dmemRdata;

         if (w_next == DONE)
            pcNext <= w_taken ? w_alu : w_npc;
      end
   end

endmodule

// File: tb/tb_mem_acc_stage.sv
// ---------------------------------------------------------------------------
// tb_mem_acc_stage
// Self-checking bench for mem_acc_stage. Each operation pushes its expected
// completion (kind, pcNext, lmdOut, cycle) onto a scoreboard; a monitor pops
// and compares whenever the stage signals memDone or memErr.
// ---------------------------------------------------------------------------
module tb_mem_acc_stage;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rstN;
   logic        memStart;
   logic        memRead;
   logic        memWrite;
   logic        branchSig;
   logic        condOut;
   logic [31:0] aluOOut;
   logic [31:0] regBOut;
   logic [31:0] npcOut;
   logic [31:0] lmdOut;
   logic [31:0] pcNext;
   logic        pcWe;
   logic        memDone;
   logic        memErr;
   logic        busy;

   mem_acc_stage_if #(.DATA_W(32)) bus ();

   mem_acc_stage #(.TIMEOUT(TIMEOUT), .DATA_W(32)) dut (
      .clk       (clk),
      .rstN      (rstN),
      .memStart  (memStart),
      .memRead   (memRead),
      .memWrite  (memWrite),
      .branchSig (branchSig),
      .condOut   (condOut),
      .aluOOut   (aluOOut),
      .regBOut   (regBOut),
      .npcOut    (npcOut),
      .dmem      (bus),
      .lmdOut    (lmdOut),
      .pcNext    (pcNext),
      .pcWe      (pcWe),
      .memDone   (memDone),
      .memErr    (memErr),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          isErr;
      logic [31:0] pc;
      logic [31:0] lmd;
      int          doneCycle;
      string       tag;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cycle = 0;
   int          reqCycles = 0;
   logic [31:0] modelPc = 32'h0;
   logic [31:0] modelLmd = 32'h0;

   // Free-running cycle count, stable when sampled on the falling edge.
   always @(posedge clk) cycle <= cycle + 1;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   // Completion monitor: every memDone/memErr pulse must match the oldest
   // outstanding expectation, including the cycle on which it appears.
   always @(negedge clk) begin
      exp_t e;
      if (rstN) begin
         if (bus.dmemReq) reqCycles++;
         if (memDone || memErr) begin
            if (sb.size() == 0) begin
               checkOutput("unexpectedCompletion", {30'b0, memDone, memErr}, 32'h0);
            end else begin
               e = sb.pop_front();
               checkOutput({e.tag, ".memErr"},  {31'b0, memErr},  {31'b0, e.isErr});
               checkOutput({e.tag, ".memDone"}, {31'b0, memDone}, {31'b0, !e.isErr});
               checkOutput({e.tag, ".pcWe"},    {31'b0, pcWe},    {31'b0, !e.isErr});
               checkOutput({e.tag, ".pcNext"},  pcNext, e.pc);
               checkOutput({e.tag, ".lmdOut"},  lmdOut, e.lmd);
               checkOutput({e.tag, ".cycle"},   32'(cycle), 32'(e.doneCycle));
            end
         end
      end
   end

   // Drives one operation, acts as the memory (ack after 'waits' wait
   // cycles, or never when waits<0) and waits for the scoreboard to drain.
   task automatic applyStimulus(input bit rd, input bit wr, input bit br, input bit cd,
                                input logic [31:0] alu, input logic [31:0] rb,
                                input logic [31:0] npc, input int waits,
                                input logic [31:0] rdata, input string tag);
      bit   fault;
      bit   isMem;
      bit   tmo;
      int   lat;
      int   expReq;
      exp_t e;
      fault = (rd && wr) || ((rd || wr) && (alu[1:0] != 2'b00));
      isMem = (rd || wr) && !fault;
      tmo   = isMem && (waits < 0);
      if (!isMem)       lat = 1;
      else if (!tmo)    lat = 2 + waits;
      else              lat = TIMEOUT + 1;
      expReq = !isMem ? 0 : (tmo ? TIMEOUT : waits + 1);
      if (!fault && !tmo) begin
         modelPc = (br && cd) ? alu : npc;
         if (rd) modelLmd = rdata;
      end

      @(negedge clk);
      memRead = rd; memWrite = wr; branchSig = br; condOut = cd;
      aluOOut = alu; regBOut = rb; npcOut = npc;
      e.isErr = fault || tmo; e.pc = modelPc; e.lmd = modelLmd;
      e.doneCycle = cycle + lat; e.tag = tag;
      sb.push_back(e);
      reqCycles = 0;
      memStart = 1'b1;

      // Scramble operands right after the start to prove they were latched.
      @(negedge clk);
      memStart = 1'b0;
      aluOOut = $urandom; regBOut = $urandom; npcOut = $urandom;
      branchSig = 1'($urandom); condOut = 1'($urandom);

      if (isMem && waits >= 0) begin
         for (int i = 0; i < waits; i++) @(negedge clk);
         checkOutput({tag, ".busy"},      {31'b0, busy},        32'h1);
         checkOutput({tag, ".dmemAddr"},  bus.dmemAddr,         alu);
         checkOutput({tag, ".dmemWe"},    {31'b0, bus.dmemWe},  {31'b0, wr});
         checkOutput({tag, ".dmemWdata"}, bus.dmemWdata,        wr ? rb : 32'h0);
         bus.dmemAck = 1'b1;
         bus.dmemRdata = rdata;
         @(negedge clk);
         bus.dmemAck = 1'b0;
         bus.dmemRdata = $urandom;
      end

      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      checkOutput({tag, ".drained"}, 32'(sb.size()), 32'h0);
      sb.delete();
      @(negedge clk);
      checkOutput({tag, ".reqCycles"}, 32'(reqCycles), 32'(expReq));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog simulation did not finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rstN = 1'b0; memStart = 1'b0; memRead = 1'b0; memWrite = 1'b0;
      branchSig = 1'b0; condOut = 1'b0; aluOOut = 32'h0; regBOut = 32'h0;
      npcOut = 32'h0; bus.dmemAck = 1'b0; bus.dmemRdata = 32'h0;
      repeat (3) @(negedge clk);
      checkOutput("reset.dmemReq", {31'b0, bus.dmemReq}, 32'h0);
      checkOutput("reset.busy",    {31'b0, busy},        32'h0);
      checkOutput("reset.pcWe",    {31'b0, pcWe},        32'h0);
      checkOutput("reset.lmdOut",  lmdOut,               32'h0);
      checkOutput("reset.pcNext",  pcNext,               32'h0);
      rstN = 1'b1;
      @(negedge clk);

      applyStimulus(0, 0, 0, 0, 32'h0000_0010, 32'h0, 32'h0000_0104, 0, 32'h0, "aluOp");
      applyStimulus(0, 0, 1, 1, 32'h0000_0200, 32'h0, 32'h0000_0108, 0, 32'h0, "brTaken");
      applyStimulus(0, 0, 1, 0, 32'h0000_0200, 32'h0, 32'h0000_0108, 0, 32'h0, "brNotTaken");
      applyStimulus(1, 0, 0, 0, 32'h0000_0040, 32'h0, 32'h0000_010C, 3, 32'hDEAD_BEEF, "load3w");
      applyStimulus(0, 1, 0, 0, 32'h0000_0080, 32'h1234_5678, 32'h0000_0110, 0, 32'h5555_AAAA, "store0w");
      applyStimulus(1, 0, 0, 0, 32'h0000_0042, 32'h0, 32'h0000_0114, 0, 32'h0, "loadMisalign");
      applyStimulus(0, 1, 0, 0, 32'h0000_0083, 32'h0, 32'h0000_0114, 0, 32'h0, "storeMisalign");
      applyStimulus(1, 1, 0, 0, 32'h0000_0010, 32'h0, 32'h0000_0114, 0, 32'h0, "readWrite");
      applyStimulus(1, 0, 0, 0, 32'h0000_0044, 32'h0, 32'h0000_0118, -1, 32'h0, "loadTimeout");
      applyStimulus(1, 0, 0, 0, 32'h0000_0048, 32'h0, 32'h0000_011C, TIMEOUT - 1, 32'h0BAD_F00D, "ackAtLimit");
      applyStimulus(1, 0, 1, 1, 32'h0000_004C, 32'h0, 32'h0000_0120, 1, 32'h1357_9BDF, "loadBranch");

      // Asynchronous reset in the middle of a bus wait.
      @(negedge clk);
      memRead = 1'b1; memWrite = 1'b0; branchSig = 1'b0; aluOOut = 32'h0000_0100;
      memStart = 1'b1;
      @(negedge clk);
      memStart = 1'b0;
      @(negedge clk);
      checkOutput("midReq.dmemReq", {31'b0, bus.dmemReq}, 32'h1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("asyncRst.dmemReq",  {31'b0, bus.dmemReq}, 32'h0);
      checkOutput("asyncRst.dmemWe",   {31'b0, bus.dmemWe},  32'h0);
      checkOutput("asyncRst.dmemAddr", bus.dmemAddr,         32'h0);
      checkOutput("asyncRst.busy",     {31'b0, busy},        32'h0);
      checkOutput("asyncRst.lmdOut",   lmdOut,               32'h0);
      checkOutput("asyncRst.pcNext",   pcNext,               32'h0);
      checkOutput("asyncRst.flags", {29'b0, pcWe, memDone, memErr}, 32'h0);
      modelPc = 32'h0; modelLmd = 32'h0;
      @(negedge clk);
      rstN = 1'b1;
      bus.dmemAck = 1'b1; bus.dmemRdata = 32'hBAD0_BAD0;
      @(negedge clk);
      bus.dmemAck = 1'b0;
      @(negedge clk);
      checkOutput("lateAck.lmdOut", lmdOut,        32'h0);
      checkOutput("lateAck.busy",   {31'b0, busy}, 32'h0);
      memRead = 1'b0;

      applyStimulus(1, 0, 0, 0, 32'h0000_0050, 32'h0, 32'h0000_0124, 0, 32'hCAFE_F00D, "afterReset");

      for (int n = 0; n < 6; n++) begin
         logic [31:0] a;
         a = {20'h0, 10'($urandom), 2'b00};
         applyStimulus(1'($urandom), 1'b0, 1'($urandom), 1'($urandom), a,
                       $urandom, $urandom, int'($urandom_range(0, 2)), $urandom,
                       $sformatf("rand%0d", n));
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, a, $urandom, $urandom,
                       int'($urandom_range(0, 2)), $urandom, $sformatf("randSt%0d", n));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_acc_stage.md
Name: mem_acc_stage

Overview:
Memory-access stage of the multicycle CPU, directly downstream of the execute stage. It consumes the latched ALU result (aluOOut), the store operand (regBOut), the branch condition (condOut) and the sequential PC (npcOut). It runs one data-memory transaction over a req/ack bus, captures load data into the LMD register, and produces the next-PC value with a one-cycle PC write strobe.

Parameters:
TIMEOUT, 15, max cycles dmemReq stays high without dmemAck before abort (1..255)
DATA_W, 32, data/address width; fixed at 32 in this design

Ports:
clk  in  1  system clock, rising edge
rstN  in  1  asynchronous active-low reset
memStart  in  1  one-cycle start pulse from control unit
memRead  in  1  load instruction (sampled with memStart)
memWrite  in  1  store instruction (sampled with memStart)
branchSig  in  1  instruction is a conditional branch (sampled with memStart)
condOut  in  1  branch condition from execute stage (sampled with memStart)
aluOOut  in  32  effective address or branch target
regBOut  in  32  store data
npcOut  in  32  PC+4
dmemReq  out  1  bus request, held until ack or abort
dmemWe  out  1  bus write enable, valid while dmemReq=1
dmemAddr  out  32  bus address (word aligned)
dmemWdata  out  32  bus write data
dmemRdata  in  32  bus read data, valid with dmemAck
dmemAck  in  1  bus acknowledge, single cycle
lmdOut  out  32  load memory data register
pcNext  out  32  next PC value
pcWe  out  1  PC write strobe, one cycle
memDone  out  1  stage complete, one cycle
memErr  out  1  fault pulse, one cycle
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rstN=0): state=IDLE; dmemReq, dmemWe, pcWe, memDone, memErr, busy=0; dmemAddr, dmemWdata, lmdOut, pcNext, timeout counter=0. Reset during REQ drops dmemReq immediately; a late ack after reset is ignored.
- Capture registers: on memStart in IDLE, latch aluOOut, regBOut, npcOut, memRead, memWrite, branchSig and condOut. Later changes on these inputs have no effect until the next start.
- FSM states: IDLE, REQ, DONE, ERR. All outputs are registered.
- IDLE + memStart:
  - memRead&memWrite=1 -> ERR.
  - (memRead|memWrite) and aluOOut[1:0]!=0 -> ERR. No bus cycle is issued.
  - memRead|memWrite -> REQ; dmemReq=1 and dmemWe=memWrite from the next cycle.
  - Neither set -> DONE.
- memStart while busy=1 is ignored.
- REQ:
  - dmemAddr = latched address; dmemWdata = latched regBOut (0 for loads).
  - Counter increments every REQ cycle without ack.
  - dmemAck=1 -> dmemReq=0 next cycle. On a load, lmdOut<=dmemRdata on the ack edge. Go to DONE.
  - Counter reaches TIMEOUT with no ack -> drop dmemReq, go to ERR. An ack on the same cycle the counter hits TIMEOUT wins: DONE.
- DONE (1 cycle): memDone=1, pcWe=1, then IDLE.
  - pcNext = latched aluOOut if (branchSig & condOut), else latched npcOut.
  - pcNext holds its value afterwards.
- ERR (1 cycle): memErr=1, pcWe=0, then IDLE. lmdOut and pcNext are unchanged.
- Stores never modify lmdOut. Non-load operations leave lmdOut unchanged.
- Latency from memStart at cycle 0:
  - Non-memory op: memDone at cycle 1.
  - Memory op with ack on the first REQ cycle (cycle 1): memDone at cycle 2. Each wait cycle adds 1.

Test Plan:
- ALU op: memStart with read=write=0, branchSig=0, npcOut=0x104 -> cycle 1 pcWe=1, pcNext=0x104, memDone=1, no dmemReq.
- Taken branch: branchSig=1, condOut=1, aluOOut=0x200, npcOut=0x108 -> pcNext=0x200. Repeat with condOut=0 -> pcNext=0x108.
- Load, 3 wait states: memRead=1, aluOOut=0x40. Ack on 4th REQ cycle with dmemRdata=0xDEADBEEF -> dmemAddr=0x40, dmemWe=0, lmdOut=0xDEADBEEF, memDone at cycle 5.
- Store, immediate ack: memWrite=1, aluOOut=0x80, regBOut=0x12345678 -> dmemWe=1, dmemWdata=0x12345678 for 1 cycle, lmdOut unchanged, memDone at cycle 2.
- Faults:
  - Load at 0x42 -> memErr at cycle 1, no dmemReq, no pcWe.
  - Load with no ack -> dmemReq high exactly TIMEOUT (15) cycles, then memErr, pcWe never asserted.
- Reset mid-REQ: rstN low asynchronously during wait -> dmemReq=0 without waiting for a clock edge, all outputs 0. A later ack is ignored. A new memStart after release works normally.
